// File: rtl/io_uart_dma_if.sv
// Register-access and DMA-master signal bundle for io_uart_dma.
// The slave modport is the device view; master is the host/bus view.
interface io_uart_dma_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16
);
  logic              io_stb_i;
  logic              io_we_i;
  logic [1:0]        io_addr_i;
  logic [31:0]       io_data_i;
  logic              io_ack_o;
  logic [31:0]       io_data_o;
  logic              dma_cyc_i;
  logic              dma_stb_o;
  logic              dma_ack_i;
  logic              dma_we_o;
  logic [ADDR_W-1:0] dma_addr_o;
  logic [DATA_W-1:0] dma_data_o;

  modport slave (
    input  io_stb_i, io_we_i, io_addr_i, io_data_i, dma_cyc_i, dma_ack_i,
    output io_ack_o, io_data_o, dma_stb_o, dma_we_o, dma_addr_o, dma_data_o
  );

  modport master (
    output io_stb_i, io_we_i, io_addr_i, io_data_i, dma_cyc_i, dma_ack_i,
    input  io_ack_o, io_data_o, dma_stb_o, dma_we_o, dma_addr_o, dma_data_o
  );
endinterface

// File: rtl/io_uart_dma.sv
// UART 8N1 receiver feeding a framed-packet parser; parsed words are queued
// in a FIFO and written out by a simple DMA master, with a 4-register IO port.
module io_uart_dma #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  io_uart_dma_if.slave  bus,
  output logic          irq_o
);
  localparam int unsigned CNT_W   = $clog2(CLK_DIV) + 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W   = 1 + ADDR_W + DATA_W;
  localparam int unsigned A_BYTES = ADDR_W / 8;
  localparam int unsigned D_BYTES = DATA_W / 8;
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {P_SYNC, P_ADDR, P_LEN, P_DATA} p_state_e;
  typedef enum logic [1:0] {D_IDLE, D_REQ, D_GAP} d_state_e;

  // ---------------- UART receiver ----------------
  rx_state_e        rx_state_q, rx_state_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_vld_q, byte_vld_d;
  logic             ferr_evt;

  always_comb begin
    rx_state_d = rx_state_q;
    baud_cnt_d = baud_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_vld_d = 1'b0;
    ferr_evt   = 1'b0;
    unique case (rx_state_q)
      R_IDLE: begin
        baud_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = R_START;
      end
      R_START: if (baud_cnt_q == CNT_W'(CLK_DIV/2 - 1)) begin
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (baud_cnt_q == CNT_W'(CLK_DIV - 1)) begin
        baud_cnt_d = '0;
        shift_d    = {rx_sync_q, shift_q[7:1]};
        bit_idx_d  = bit_idx_q + 1'b1;
        if (bit_idx_q == 3'd7) rx_state_d = R_STOP;
      end
      R_STOP: if (baud_cnt_q == CNT_W'(CLK_DIV - 1)) begin
        rx_state_d = R_IDLE;
        if (rx_sync_q) byte_vld_d = 1'b1;
        else           ferr_evt   = 1'b1;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= R_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      byte_vld_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      byte_vld_q <= byte_vld_d;
    end
  end

  // ---------------- frame parser ----------------
  p_state_e          p_state_q, p_state_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       len_q, len_d, word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              push;
  logic [ENT_W-1:0]  push_ent;

  always_comb begin
    p_state_d  = p_state_q;
    byte_cnt_d = byte_cnt_q;
    waddr_d    = waddr_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    wdata_d    = wdata_q;
    push       = 1'b0;
    push_ent   = '0;
    if (byte_vld_q) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
      unique case (p_state_q)
        P_SYNC: begin
          byte_cnt_d = '0;
          if (shift_q == 8'hA5) p_state_d = P_ADDR;
        end
        P_ADDR: begin
          waddr_d = (waddr_q << 8) | ADDR_W'(shift_q);
          if (byte_cnt_q == 8'(A_BYTES - 1)) begin
            byte_cnt_d = '0;
            p_state_d  = P_LEN;
          end
        end
        P_LEN: begin
          len_d = {len_q[7:0], shift_q};
          if (byte_cnt_q == 8'd1) begin
            byte_cnt_d = '0;
            word_cnt_d = '0;
            p_state_d  = (len_d == '0) ? P_SYNC : P_DATA;
          end
        end
        P_DATA: begin
          // Bytes enter at the top and shift down, so the first byte ends in [7:0].
          wdata_d = (wdata_q >> 8) | (DATA_W'(shift_q) << (DATA_W - 8));
          if (byte_cnt_q == 8'(D_BYTES - 1)) begin
            byte_cnt_d = '0;
            word_cnt_d = word_cnt_q + 1'b1;
            push       = 1'b1;
            push_ent   = {word_cnt_d == len_q, waddr_q, wdata_d};
            waddr_d    = waddr_q + 1'b1;
            if (word_cnt_d == len_q) p_state_d = P_SYNC;
          end
        end
        default: p_state_d = P_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state_q  <= P_SYNC;
      byte_cnt_q <= '0;
      waddr_q    <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      wdata_q    <= '0;
    end else begin
      p_state_q  <= p_state_d;
      byte_cnt_q <= byte_cnt_d;
      waddr_q    <= waddr_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      wdata_q    <= wdata_d;
    end
  end

  // ---------------- word FIFO ----------------
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             full, empty, pop, do_push, ovf_evt;
  logic [ENT_W-1:0] head;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // When full, a same-cycle pop frees the slot being written; the popped
  // entry was already captured into the DMA output registers.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    do_push  = push && (!full || pop);
    ovf_evt  = push && full && !pop;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_ent;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !do_push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // ---------------- DMA master ----------------
  d_state_e          d_state_q, d_state_d;
  logic              dma_stb_q, dma_stb_d, dma_last_q, dma_last_d;
  logic [ADDR_W-1:0] dma_addr_q, dma_addr_d, last_addr_q, last_addr_d;
  logic [DATA_W-1:0] dma_data_q, dma_data_d;
  logic              irq_q, irq_d;
  logic [31:0]       frames_q, frames_d;
  logic              en_q, en_d;

  assign pop = (d_state_q == D_REQ) && bus.dma_ack_i;

  always_comb begin
    d_state_d   = d_state_q;
    dma_stb_d   = dma_stb_q;
    dma_last_d  = dma_last_q;
    dma_addr_d  = dma_addr_q;
    dma_data_d  = dma_data_q;
    last_addr_d = last_addr_q;
    frames_d    = frames_q;
    irq_d       = 1'b0;
    unique case (d_state_q)
      D_IDLE: if (!empty && en_q && bus.dma_cyc_i) begin
        d_state_d = D_REQ;
        dma_stb_d = 1'b1;
        {dma_last_d, dma_addr_d, dma_data_d} = head;
      end
      D_REQ: if (bus.dma_ack_i) begin
        d_state_d = D_GAP;
        dma_stb_d = 1'b0;
        if (dma_last_q) begin
          irq_d       = 1'b1;
          frames_d    = frames_q + 1'b1;
          last_addr_d = dma_addr_q;
        end
      end
      D_GAP:   d_state_d = D_IDLE;
      default: d_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_state_q   <= D_IDLE;
      dma_stb_q   <= 1'b0;
      dma_last_q  <= 1'b0;
      dma_addr_q  <= '0;
      dma_data_q  <= '0;
      last_addr_q <= '0;
      frames_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      d_state_q   <= d_state_d;
      dma_stb_q   <= dma_stb_d;
      dma_last_q  <= dma_last_d;
      dma_addr_q  <= dma_addr_d;
      dma_data_q  <= dma_data_d;
      last_addr_q <= last_addr_d;
      frames_q    <= frames_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.dma_stb_o  = dma_stb_q;
  assign bus.dma_we_o   = dma_stb_q;
  assign bus.dma_addr_o = dma_addr_q;
  assign bus.dma_data_o = dma_data_q;
  assign irq_o          = irq_q;

  // ---------------- IO registers ----------------
  logic        io_ack_q, io_ack_d;
  logic [31:0] io_rdata_q, io_rdata_d;
  logic        ovf_q, ovf_d, ferr_q, ferr_d, clr;

  always_comb begin
    io_ack_d   = 1'b0;
    io_rdata_d = '0;
    en_d       = en_q;
    clr        = 1'b0;
    if (bus.io_stb_i && !io_ack_q) begin
      io_ack_d = 1'b1;
      unique case (bus.io_addr_i)
        2'd0:    io_rdata_d = {31'b0, en_q};
        2'd1:    io_rdata_d = {16'b0, 8'(level_q), 4'b0, ferr_q, ovf_q,
                               d_state_q != D_IDLE, p_state_q != P_SYNC};
        2'd2:    io_rdata_d = frames_q;
        default: io_rdata_d = 32'(last_addr_q);
      endcase
      if (bus.io_we_i && bus.io_addr_i == 2'd0) begin
        en_d = bus.io_data_i[0];
        clr  = bus.io_data_i[1];
      end
    end
    // A new event in the same cycle as a clear wins.
    ovf_d  = (ovf_q  && !clr) || ovf_evt;
    ferr_d = (ferr_q && !clr) || ferr_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_ack_q   <= 1'b0;
      io_rdata_q <= '0;
      en_q       <= 1'b1;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      io_ack_q   <= io_ack_d;
      io_rdata_q <= io_rdata_d;
      en_q       <= en_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bus.io_ack_o  = io_ack_q;
  assign bus.io_data_o = io_rdata_q;
endmodule

// File: tb/tb_io_uart_dma.sv
// Bench for io_uart_dma: serial frames in, DMA writes checked against a
// scoreboard of expected {addr, data}; register state checked over the IO port.
module tb_io_uart_dma;
  localparam int unsigned CLK_DIV = 16;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic irq_o;
  logic ack_drv = 1'b0;
  logic resp_en = 1'b0;

  io_uart_dma_if #(.DATA_W(32), .ADDR_W(16)) bus ();

  io_uart_dma #(
    .CLK_DIV(CLK_DIV), .DATA_W(32), .ADDR_W(16), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .bus(bus.slave), .irq_o(irq_o)
  );

  assign bus.dma_ack_i = ack_drv;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] n;
    logic [31:0] base;
    logic [31:0] exp_frames;
    logic [31:0] exp_last;
  } frame_vec_t;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] exp;
  } reg_vec_t;

  wr_t         sb_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned irq_cnt = 0;
  int unsigned wr_cnt = 0;
  int unsigned wait_cnt = 0;
  logic [15:0] first_addr;
  logic [31:0] first_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // DMA slave model: acknowledge two cycles after the request appears.
  always @(negedge clk) begin
    wr_t e;
    if (ack_drv) begin
      ack_drv  = 1'b0;
      wait_cnt = 0;
    end else if (resp_en && bus.dma_stb_o) begin
      wait_cnt++;
      if (wait_cnt == 1) begin
        first_addr = bus.dma_addr_o;
        first_data = bus.dma_data_o;
      end
      if (wait_cnt == 2) begin
        ack_drv = 1'b1;
        wr_cnt++;
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL dma_unexpected: write addr %h data %h, none expected",
                   bus.dma_addr_o, bus.dma_data_o);
        end else begin
          e = sb_q.pop_front();
          check("dma_addr", 32'(bus.dma_addr_o), 32'(e.addr));
          check("dma_data", bus.dma_data_o, e.data);
          check("dma_we", 32'(bus.dma_we_o), 32'd1);
          check("dma_hold_addr", 32'(first_addr), 32'(e.addr));
          check("dma_hold_data", first_data, e.data);
        end
      end
    end
  end

  always @(negedge clk) if (irq_o === 1'b1) irq_cnt++;

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) rx = 1'b0;
    repeat (CLK_DIV - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx = b[i];
      repeat (CLK_DIV - 1) @(negedge clk);
    end
    @(negedge clk) rx = stop;
    repeat (CLK_DIV - 1) @(negedge clk);
    @(negedge clk) rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] n,
                            input logic [31:0] base, input int unsigned keep);
    wr_t         e;
    logic [31:0] w;
    send_byte(8'hA5, 1'b1);
    send_byte(a[15:8], 1'b1);
    send_byte(a[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
    send_byte(n[7:0], 1'b1);
    for (int unsigned i = 0; i < 32'(n); i++) begin
      w = base + i;
      if (i < keep) begin
        e.addr = a + 16'(i);
        e.data = w;
        sb_q.push_back(e);
      end
      for (int unsigned k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    end
  endtask

  task automatic io_access(input logic we, input logic [1:0] a, input logic [31:0] wd,
                           output logic [31:0] rd);
    @(negedge clk);
    bus.io_stb_i  = 1'b1;
    bus.io_we_i   = we;
    bus.io_addr_i = a;
    bus.io_data_i = wd;
    @(negedge clk);
    check("io_ack", 32'(bus.io_ack_o), 32'd1);
    rd = bus.io_data_o;
    bus.io_stb_i = 1'b0;
    bus.io_we_i  = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned t = 0;
    while ((sb_q.size() != 0 || bus.dma_stb_o) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check({name, "_drain"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_vec_t  fv [2];
    reg_vec_t    rv [4];
    logic [31:0] rd;
    int unsigned wr0, irq0, t;

    fv[0] = '{16'h1234, 16'd2, 32'h0000_0001, 32'd1, 32'h0000_1235};
    fv[1] = '{16'hFFFF, 16'd2, 32'hC0DE_0000, 32'd2, 32'h0000_0000};
    rv[0] = '{2'd0, 32'h1};
    rv[1] = '{2'd1, 32'h0};
    rv[2] = '{2'd2, 32'h0};
    rv[3] = '{2'd3, 32'h0};

    rst           = 1'b1;
    rx            = 1'b1;
    bus.io_stb_i  = 1'b0;
    bus.io_we_i   = 1'b0;
    bus.io_addr_i = '0;
    bus.io_data_i = '0;
    bus.dma_cyc_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_stb", 32'(bus.dma_stb_o), 32'd0);
    check("rst_we", 32'(bus.dma_we_o), 32'd0);
    check("rst_addr", 32'(bus.dma_addr_o), 32'd0);
    check("rst_data", bus.dma_data_o, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_io_ack", 32'(bus.io_ack_o), 32'd0);
    check("rst_io_data", bus.io_data_o, 32'd0);
    rst     = 1'b0;
    resp_en = 1'b1;

    for (int i = 0; i < 4; i++) begin
      io_access(1'b0, rv[i].a, 32'd0, rd);
      check("reset_reg", rd, rv[i].exp);
    end
    @(negedge clk);
    check("io_data_idle", bus.io_data_o, 32'd0);

    for (int i = 0; i < 2; i++) begin
      wr0 = wr_cnt;
      send_frame(fv[i].addr, fv[i].n, fv[i].base, 32'(fv[i].n));
      drain("frame");
      check("frame_writes", 32'(wr_cnt - wr0), 32'(fv[i].n));
      check("frame_irq", 32'(irq_cnt), fv[i].exp_frames);
      io_access(1'b0, 2'd2, 32'd0, rd);
      check("frame_frames", rd, fv[i].exp_frames);
      io_access(1'b0, 2'd3, 32'd0, rd);
      check("frame_last_addr", rd, fv[i].exp_last);
    end

    // No grant: 8 words fill the FIFO, the last 2 (including last=1) are dropped.
    bus.dma_cyc_i = 1'b0;
    wr0  = wr_cnt;
    irq0 = irq_cnt;
    send_frame(16'h2000, 16'd10, 32'h0000_0100, 8);
    io_access(1'b0, 2'd1, 32'd0, rd);
    check("ovf_status", rd, 32'h0000_0804);
    check("ovf_no_writes", 32'(wr_cnt - wr0), 32'd0);
    bus.dma_cyc_i = 1'b1;
    drain("ovf");
    check("ovf_writes", 32'(wr_cnt - wr0), 32'd8);
    check("ovf_no_irq", 32'(irq_cnt), 32'(irq0));
    io_access(1'b0, 2'd2, 32'd0, rd);
    check("ovf_frames", rd, 32'd2);
    io_access(1'b1, 2'd0, 32'h3, rd);
    io_access(1'b0, 2'd1, 32'd0, rd);
    check("ovf_cleared", rd, 32'h0);

    send_byte(8'hA5, 1'b0);
    io_access(1'b0, 2'd1, 32'd0, rd);
    check("ferr_status", rd, 32'h0000_0008);
    io_access(1'b1, 2'd0, 32'h3, rd);
    io_access(1'b0, 2'd1, 32'd0, rd);
    check("ferr_cleared", rd, 32'h0);

    wr0  = wr_cnt;
    irq0 = irq_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    io_access(1'b0, 2'd1, 32'd0, rd);
    check("junk_sync", rd, 32'h0);
    send_byte(8'hA5, 1'b1);
    io_access(1'b0, 2'd1, 32'd0, rd);
    check("sync_busy", rd, 32'h1);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
    repeat (50) @(negedge clk);
    io_access(1'b0, 2'd1, 32'd0, rd);
    check("n0_status", rd, 32'h0);
    check("n0_writes", 32'(wr_cnt - wr0), 32'd0);
    check("n0_irq", 32'(irq_cnt), 32'(irq0));

    // Reset while a request is outstanding.
    resp_en = 1'b0;
    irq0    = irq_cnt;
    send_frame(16'h3000, 16'd1, 32'h0000_0077, 1);
    t = 0;
    while (!bus.dma_stb_o && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("rstreq_stb", 32'(bus.dma_stb_o), 32'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstreq_stb_drop", 32'(bus.dma_stb_o), 32'd0);
    @(negedge clk) rst = 1'b0;
    sb_q.delete();
    resp_en = 1'b1;
    repeat (20) @(negedge clk);
    check("rstreq_idle", 32'(bus.dma_stb_o), 32'd0);
    io_access(1'b0, 2'd1, 32'd0, rd);
    check("rstreq_status", rd, 32'h0);
    io_access(1'b0, 2'd2, 32'd0, rd);
    check("rstreq_frames", rd, 32'h0);
    io_access(1'b0, 2'd0, 32'd0, rd);
    check("rstreq_ctrl", rd, 32'h1);
    check("rstreq_irq", 32'(irq_cnt), 32'(irq0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
